mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Sits directly downstream of the cache block and upstream of the single-ported RAM.
- Arbitrates the cache's instruction-fetch and data requests onto the RAM, one transaction at a time.
- Drives the iwait/dwait handshakes back to the cache and returns load data.
- Registered FSM, data-first with round-robin fairness; sticky error flag on RAM error or transaction timeout.

Parameters:
- TIMEOUT, default 255: cycles a granted transaction may wait for ACCESS before memerr is set.
- ADDR_W, default 32: address width.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- iREN  in  1  instruction read request from cache.
- iaddr  in  ADDR_W  instruction address.
- dREN  in  1  data read request.
- dWEN  in  1  data write request.
- daddr  in  ADDR_W  data address.
- dstore  in  32  data write value.
- iwait  out  1  low for exactly the cycle instruction data is valid.
- dwait  out  1  low for exactly the cycle a data read/write completes.
- iload  out  32  instruction read data.
- dload  out  32  data read data.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  ADDR_W  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR.
- memerr  out  1  sticky error flag.

Behaviour:
- States: IDLE, IGRANT, DGRANT. Also holds:
  - last-served flag `last_d`;
  - latched `addr`, `store`, `wr`;
  - timeout counter `tcnt`, width clog2(TIMEOUT+1).
- Reset (async, nRST=0):
  - state=IDLE, last_d=0, tcnt=0, memerr=0, latches=0.
  - Hence ramREN=ramWEN=0, iwait=dwait=1.
  - Reset asserted mid-transaction aborts it immediately; no completion is signalled.
- IDLE, arbitration on the current-cycle requests:
  - d_req = dREN|dWEN.
  - d_req & iREN: grant DGRANT if last_d=0, else IGRANT.
  - d_req alone: DGRANT. iREN alone: IGRANT. Neither: stay.
  - On a DGRANT transition latch addr=daddr, store=dstore, wr=dWEN. dWEN wins if dREN and dWEN are both high.
  - On an IGRANT transition latch addr=iaddr, wr=0.
  - tcnt cleared.
  - No RAM enable asserted in IDLE, so a request sees its RAM enable one cycle after it is first presented.
- IGRANT / DGRANT:
  - RAM outputs combinational from state and latches: ramaddr=addr, ramstore=store.
  - ramREN = IGRANT | (DGRANT & ~wr). ramWEN = DGRANT & wr.
- Completion: ramstate==ACCESS in a grant state.
  - The matching wait goes low that same cycle.
  - iload/dload = ramload; both always pass ramload through.
  - Next state IDLE; last_d <= (state==DGRANT).
  - Each transaction completes exactly once.
  - Minimum latency is request cycle to completion cycle = 1.
  - Back-to-back requests incur one IDLE bubble.
- BUSY / FREE in a grant state: hold state, outputs unchanged, tcnt increments.
- ERROR in a grant state: memerr <= 1; state held; the request is retried (enables stay asserted).
- Timeout: tcnt reaching TIMEOUT sets memerr. tcnt saturates and the state is held; the arbiter never self-aborts.
- Request withdrawn: if the granted requester deasserts before ACCESS, next state is IDLE.
  - iREN low in IGRANT, or dREN|dWEN low in DGRANT.
  - The wait stays high; last_d is unchanged.
- Address or data changing mid-grant is ignored; the latched values are used.
- iwait=1 and dwait=1 in every cycle other than their own completion cycle.
- The non-granted requester is never acknowledged.
- memerr is cleared only by reset.

Test Plan:
1. Reset:
   - nRST=0 with iREN=1.
   - Expect iwait=dwait=1, ramREN=ramWEN=0, memerr=0.
   - After release, ramREN=1 one cycle after iREN is sampled in IDLE.
2. Single fetch:
   - iREN=1, iaddr=0x0000_0040; RAM gives BUSY×2 then ACCESS with ramload=0x2001_0005.
   - Expect iwait low only in the ACCESS cycle, iload=0x2001_0005, dwait=1 throughout.
3. Contention and fairness:
   - iREN=1 and dWEN=1 held; daddr=0x80, dstore=0xDEAD_BEEF; RAM ACCESS immediately.
   - Expect grants D, I, D, I alternating.
   - Each D grant shows ramWEN=1, ramaddr=0x80, ramstore=0xDEADBEEF.
4. Withdrawal:
   - dREN dropped while RAM reports BUSY.
   - Expect return to IDLE next cycle with no dwait pulse.
   - A following iREN is granted even though last_d=0.
5. Error and timeout:
   - ramstate=ERROR one cycle then ACCESS: memerr=1 sticky and the read still completes.
   - Separately, with TIMEOUT=4, BUSY held 5 cycles: memerr rises at tcnt=4.
6. Async reset mid-DGRANT:
   - Expect enables drop immediately (no clock edge needed), state=IDLE, no dwait pulse.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and data requests from the cache onto a single-ported RAM.
// One transaction at a time, data-first with round-robin fairness, sticky error flag.
module mem_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int ADDR_W  = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [31:0]       dstore,
  output logic              iwait,
  output logic              dwait,
  output logic [31:0]       iload,
  output logic [31:0]       dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [31:0]       ramstore,
  input  logic [31:0]       ramload,
  input  logic [1:0]        ramstate,
  output logic              memerr
);

  localparam int TCNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TCNT_W-1:0] TCNT_MAX = TCNT_W'(TIMEOUT);

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_last_d;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_store;
  logic                r_wr;
  logic [TCNT_W-1:0]   r_tcnt;
  logic                r_memerr;

  state_t              w_state_next;
  logic                w_last_d_next;
  logic [ADDR_W-1:0]   w_addr_next;
  logic [31:0]         w_store_next;
  logic                w_wr_next;
  logic [TCNT_W-1:0]   w_tcnt_next;
  logic                w_memerr_next;

  logic                w_d_req;
  logic                w_access;
  logic                w_error;
  logic [TCNT_W-1:0]   w_tcnt_sat;

  assign w_d_req  = dREN | dWEN;
  assign w_access = (ramstate == RAM_ACCESS);
  assign w_error  = (ramstate == RAM_ERROR);
  // Saturating increment: the arbiter keeps waiting after a timeout, it only flags it.
  assign w_tcnt_sat = (r_tcnt == TCNT_MAX) ? r_tcnt : r_tcnt + 1'b1;

  assign ramaddr  = r_addr;
  assign ramstore = r_store;
  assign iload    = ramload;
  assign dload    = ramload;
  assign memerr   = r_memerr;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state  <= IDLE;
      r_last_d <= 1'b0;
      r_addr   <= '0;
      r_store  <= '0;
      r_wr     <= 1'b0;
      r_tcnt   <= '0;
      r_memerr <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_last_d <= w_last_d_next;
      r_addr   <= w_addr_next;
      r_store  <= w_store_next;
      r_wr     <= w_wr_next;
      r_tcnt   <= w_tcnt_next;
      r_memerr <= w_memerr_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_last_d_next = r_last_d;
    w_addr_next   = r_addr;
    w_store_next  = r_store;
    w_wr_next     = r_wr;
    w_tcnt_next   = r_tcnt;
    w_memerr_next = r_memerr;
    iwait         = 1'b1;
    dwait         = 1'b1;
    ramREN        = 1'b0;
    ramWEN        = 1'b0;

    case (r_state)
      IDLE: begin
        w_tcnt_next = '0;
        // Data wins unless it was served last and an instruction fetch is also waiting.
        if (w_d_req && (!iREN || !r_last_d)) begin
          w_state_next = DGRANT;
          w_addr_next  = daddr;
          w_store_next = dstore;
          w_wr_next    = dWEN;
        end else if (iREN) begin
          w_state_next = IGRANT;
          w_addr_next  = iaddr;
          w_wr_next    = 1'b0;
        end
      end

      IGRANT: begin
        ramREN = 1'b1;
        if (!iREN) begin
          w_state_next = IDLE;
        end else if (w_access) begin
          iwait         = 1'b0;
          w_state_next  = IDLE;
          w_last_d_next = 1'b0;
        end else begin
          w_tcnt_next = w_tcnt_sat;
          if (w_tcnt_sat == TCNT_MAX) w_memerr_next = 1'b1;
        end
      end

      DGRANT: begin
        ramREN = ~r_wr;
        ramWEN = r_wr;
        if (!w_d_req) begin
          w_state_next = IDLE;
        end else if (w_access) begin
          dwait         = 1'b0;
          w_state_next  = IDLE;
          w_last_d_next = 1'b1;
        end else begin
          w_tcnt_next = w_tcnt_sat;
          if (w_tcnt_sat == TCNT_MAX) w_memerr_next = 1'b1;
        end
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase

    if ((r_state != IDLE) && w_error) w_memerr_next = 1'b1;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised scoreboard bench for mem_arbiter: the driver plays cache and RAM, a transaction
// model predicts each completion, and a monitor checks every wait pulse against the queue.
module tb_mem_arbiter;

  localparam int TIMEOUT = 4;

  logic        CLK;
  logic        nRST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        iwait;
  logic        dwait;
  logic [31:0] iload;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic        memerr;

  mem_arbiter #(.TIMEOUT(TIMEOUT), .ADDR_W(32)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .memerr(memerr)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    bit          is_d;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] store;
    logic [31:0] load;
  } txn_t;

  txn_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  // Reference state: who is still requesting, who was served last, whether an error was seen.
  bit pend_i;
  bit pend_d;
  bit exp_last_d;
  bit exp_memerr;
  bit scramble;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: every wait pulse must match the oldest predicted completion.
  initial begin
    txn_t t;
    forever begin
      @(negedge CLK);
      if (nRST === 1'b1 && (iwait !== 1'b1 || dwait !== 1'b1)) begin
        if (iwait === 1'b0 && dwait === 1'b0) begin
          n_cmp++; n_fail++;
          $display("FAIL both_waits: iwait=%b dwait=%b expected one high at %0t", iwait, dwait, $time);
        end else if (sb.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_ack: iwait=%b dwait=%b expected none at %0t", iwait, dwait, $time);
        end else begin
          t = sb.pop_front();
          chk("ack_port_d", 32'(dwait === 1'b0), 32'(t.is_d));
          chk("load", t.is_d ? dload : iload, t.load);
          chk("ack_ramaddr", ramaddr, t.addr);
          chk("ack_ramWEN", 32'(ramWEN), 32'(t.wr));
          chk("ack_ramREN", 32'(ramREN), 32'(!t.wr));
          if (t.wr) chk("ack_ramstore", ramstore, t.store);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic drop_winner(input bit win_d);
    if (win_d) begin
      dREN = 1'b0; dWEN = 1'b0; pend_d = 1'b0;
    end else begin
      iREN = 1'b0; pend_i = 1'b0;
    end
  endtask

  // Serve one transaction from the current IDLE cycle: n_wait non-ACCESS cycles (one may be
  // ERROR at err_at), then either ACCESS with the given load or a withdrawal by the winner.
  task automatic round(input int n_wait, input int err_at, input bit wd, input logic [31:0] load);
    bit   win_d;
    int   waited;
    txn_t t;
    if (!pend_i && !pend_d) begin
      @(posedge CLK); #1;
      return;
    end
    win_d   = pend_d && (!pend_i || !exp_last_d);
    t.is_d  = win_d;
    t.addr  = win_d ? daddr : iaddr;
    t.wr    = win_d && dWEN;
    t.store = dstore;
    t.load  = load;
    if (!wd) sb.push_back(t);
    @(posedge CLK); #1;
    chk("grant_ramREN", 32'(ramREN), 32'(!t.wr));
    chk("grant_ramWEN", 32'(ramWEN), 32'(t.wr));
    chk("grant_ramaddr", ramaddr, t.addr);
    if (t.wr) chk("grant_ramstore", ramstore, t.store);
    if (scramble) begin
      iaddr = $urandom; daddr = $urandom; dstore = $urandom;
    end
    waited = 0;
    for (int k = 0; k < n_wait; k++) begin
      ramstate = (k == err_at) ? 2'd3 : ($urandom_range(0, 1) == 1 ? 2'd1 : 2'd0);
      ramload  = $urandom;
      chk("enable_held", 32'(ramREN | ramWEN), 32'd1);
      @(posedge CLK); #1;
      waited++;
      if (k == err_at || waited >= TIMEOUT) exp_memerr = 1'b1;
      chk("memerr_wait", 32'(memerr), 32'(exp_memerr));
    end
    if (wd) begin
      drop_winner(win_d);
      ramstate = 2'd1;
      @(posedge CLK); #1;
      ramstate = 2'd0;
    end else begin
      ramstate = 2'd2;
      ramload  = load;
      @(posedge CLK); #1;
      ramstate = 2'd0;
      ramload  = $urandom;
      drop_winner(win_d);
      exp_last_d = win_d;
    end
    chk("memerr_end", 32'(memerr), 32'(exp_memerr));
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; ramstate = 2'd0;
    pend_i = 1'b0; pend_d = 1'b0; exp_last_d = 1'b0; exp_memerr = 1'b0;
    @(posedge CLK); #1;
    chk("reset_memerr", 32'(memerr), 32'd0);
    nRST = 1'b1;
  endtask

  initial begin
    nRST = 1'b0; iREN = 1'b1; iaddr = 32'h0000_0040; dREN = 1'b0; dWEN = 1'b0;
    daddr = '0; dstore = '0; ramload = '0; ramstate = 2'd0;
    pend_i = 1'b0; pend_d = 1'b0; exp_last_d = 1'b0; exp_memerr = 1'b0; scramble = 1'b0;

    // Reset held with a fetch request present: nothing may be granted.
    repeat (2) begin
      @(posedge CLK); #1;
      chk("rst_iwait", 32'(iwait), 32'd1);
      chk("rst_dwait", 32'(dwait), 32'd1);
      chk("rst_ramREN", 32'(ramREN), 32'd0);
      chk("rst_ramWEN", 32'(ramWEN), 32'd0);
      chk("rst_memerr", 32'(memerr), 32'd0);
    end

    // Release with iREN high; single fetch with two BUSY cycles.
    nRST = 1'b1; pend_i = 1'b1;
    round(2, -1, 1'b0, 32'h2001_0005);

    // Contention: D,I,D,I alternation with both requests held.
    iREN = 1'b1; pend_i = 1'b1;
    dWEN = 1'b1; daddr = 32'h80; dstore = 32'hDEAD_BEEF; pend_d = 1'b1;
    for (int r = 0; r < 4; r++) begin
      round(0, -1, 1'b0, $urandom);
      if (r < 3) begin
        if (!pend_i) begin iREN = 1'b1; pend_i = 1'b1; end
        if (!pend_d) begin dWEN = 1'b1; daddr = 32'h80; dstore = 32'hDEAD_BEEF; pend_d = 1'b1; end
      end
    end
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; pend_i = 1'b0; pend_d = 1'b0;
    @(posedge CLK); #1;

    // Withdrawal of a data read while BUSY, then a fetch.
    dREN = 1'b1; daddr = 32'h100; pend_d = 1'b1;
    round(1, -1, 1'b1, 32'h0);
    iREN = 1'b1; iaddr = 32'h44; pend_i = 1'b1;
    round(0, -1, 1'b0, 32'h1234_5678);

    // ERROR for one cycle then ACCESS: read still completes, memerr sticks.
    iREN = 1'b1; iaddr = 32'h48; pend_i = 1'b1;
    round(1, 0, 1'b0, 32'hCAFE_0001);
    @(posedge CLK); #1;
    chk("memerr_sticky", 32'(memerr), 32'd1);
    do_reset();

    // Timeout: BUSY for 5 cycles, memerr must rise exactly after the 4th.
    dREN = 1'b1; daddr = 32'h200; pend_d = 1'b1;
    round(5, -1, 1'b0, 32'h0BAD_F00D);
    do_reset();

    // Asynchronous reset in the middle of a data grant.
    dREN = 1'b1; daddr = 32'h300; pend_d = 1'b1;
    @(posedge CLK); #1;
    ramstate = 2'd1;
    chk("dgrant_ramREN", 32'(ramREN), 32'd1);
    #2 nRST = 1'b0;
    #1;
    chk("async_ramREN", 32'(ramREN), 32'd0);
    chk("async_ramWEN", 32'(ramWEN), 32'd0);
    chk("async_dwait", 32'(dwait), 32'd1);
    chk("async_iwait", 32'(iwait), 32'd1);
    dREN = 1'b0; pend_d = 1'b0; ramstate = 2'd0; exp_last_d = 1'b0; exp_memerr = 1'b0;
    @(posedge CLK); #1;
    nRST = 1'b1;
    iREN = 1'b1; iaddr = 32'h4C; pend_i = 1'b1;
    round(0, -1, 1'b0, 32'h5555_AAAA);

    // Randomised traffic.
    scramble = 1'b1;
    for (int r = 0; r < 150; r++) begin
      int  n_wait;
      int  err_at;
      bit  wd;
      if (r % 20 == 19) do_reset();
      if (!pend_i && $urandom_range(0, 2) != 0) begin
        iREN = 1'b1; iaddr = $urandom; pend_i = 1'b1;
      end
      if (!pend_d && $urandom_range(0, 2) != 0) begin
        case ($urandom_range(0, 2))
          0: begin dREN = 1'b1; dWEN = 1'b0; end
          1: begin dREN = 1'b0; dWEN = 1'b1; end
          default: begin dREN = 1'b1; dWEN = 1'b1; end
        endcase
        daddr = $urandom; dstore = $urandom; pend_d = 1'b1;
      end
      n_wait = ($urandom_range(0, 9) == 0) ? int'($urandom_range(4, 6)) : int'($urandom_range(0, 3));
      err_at = (n_wait > 0 && $urandom_range(0, 9) == 0) ? int'($urandom_range(0, n_wait - 1)) : -1;
      wd     = (n_wait > 0 && $urandom_range(0, 9) == 0);
      round(n_wait, err_at, wd, $urandom);
    end

    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
